cram_burst_feeder: RTL and testbench
====================================

# cram_burst_feeder

Upstream request stage for the CellularRAM burst engine on the NEXYS 3 board. It buffers user write words in a small FIFO, accepts a burst command (start address plus length), and holds the engine's chip-enable until the engine reports done. It presents one word per engine `Yield` and reports completion or short or over-run bursts to the user side.

## Interface
Parameters:
- `DATA_W`, 16: data word width. Matches the RAM bus.
- `ADDR_W`, 20: word address width.
- `DEPTH`, 16: FIFO depth in words. Must be a power of two.

Ports:
- `CLK`  in  1  Single clock. Rising-edge.
- `Reset`  in  1  Synchronous, active-high reset.
- `WrData`  in  DATA_W  Word to push into the FIFO.
- `WrValid`  in  1  Push request.
- `WrReady`  out  1  FIFO not full. A push happens only when `WrValid & WrReady`.
- `StartAddr`  in  ADDR_W  Burst start address. Sampled with `Start`.
- `Length`  in  5  Burst length in words. Legal range 1..DEPTH.
- `Start`  in  1  One-cycle burst command.
- `Busy`  out  1  High whenever the FSM is not in IDLE.
- `Complete`  out  1  One-cycle pulse when a burst ends.
- `Short`  out  1  Sticky. The engine signalled done before `Length` words were consumed.
- `OverYield`  out  1  Sticky. The engine yielded more than `Length` times.
- `CmdError`  out  1  One-cycle pulse when a `Start` is rejected.
- `BurstDataOut`  out  DATA_W  Drives the engine's `DataIn`.
- `BurstAddrOut`  out  ADDR_W  Drives the engine's `AddressIn`.
- `BurstCE`  out  1  Drives the engine's `CE`.
- `BurstYield`  in  1  From the engine. The current word is consumed on this edge.
- `BurstDone`  in  1  From the engine. The burst is finished.

## Operation
- FSM states: IDLE, WAIT_DATA, BURST, FINISH.
- IDLE:
  - On `Start` with `Length` in 1..DEPTH: latch `StartAddr` and `Length`, clear the word counter, go to WAIT_DATA.
  - On `Start` with `Length` of 0 or greater than DEPTH: pulse `CmdError` and stay in IDLE.
- `Start` outside IDLE is ignored. It causes no error pulse.
- WAIT_DATA: wait until FIFO count ≥ latched length, then go to BURST.
- BURST:
  - `BurstCE` = 1.
  - `BurstDataOut` = FIFO head (show-ahead).
  - Each cycle with `BurstYield`=1:
    - If the word counter < length: pop and increment the counter.
    - Otherwise: no pop, set `OverYield`, and `BurstDataOut` reads 0.
  - On `BurstDone`=1, go to FINISH. If counter < length, set `Short` and record `length − counter` as the discard count.
- FINISH:
  - Pop the remaining discarded words, one per cycle.
  - When the discard count is 0, pulse `Complete` and return to IDLE.
- `BurstAddrOut` holds the latched address from `Start` acceptance until the next accepted `Start`. Address incrementing belongs to the engine.
- Simultaneous push and pop: both take effect and the count is unchanged.
- A push while full is dropped (`WrReady`=0).
- `BurstYield` and `BurstDone` in the same cycle: the pop and counter increment happen first, then the `Short` evaluation uses the updated counter.
- `Short` and `OverYield` clear only on reset or on the next accepted `Start`.

## Timing
- Reset values:
  - FIFO empty.
  - `WrReady`=1.
  - All other outputs 0.
  - FSM in IDLE.
  - Latches and counters 0.
- Reset mid-burst: `BurstCE` drops on the cycle after the reset edge, and buffered words are lost.
- `Start` at edge N is accepted into WAIT_DATA at N+1.
- BURST is entered one cycle after the FIFO count condition is met. If data is already present, `BurstCE` rises at N+2.
- `BurstCE` drops in the cycle after `BurstDone` is sampled high.
- `Complete` pulses:
  - in the cycle after `BurstDone` when there is nothing to discard;
  - otherwise after the discard pops finish.
- `WrReady` = !full, combinational from the registered count.
- The head word changes the cycle after a pop.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=0, WAIT_DATA=1, BURST=2, FINISH=3;
  - `MAX_BURST` = 16;
  - the 16/20-bit width constants shared with the burst engine.
- One sub-module, `burst_word_fifo`: synchronous show-ahead FIFO with count, full and empty outputs, and simultaneous push/pop. The FSM, counters and sticky flags live in the top level.

## Test plan
- Push 4 words A0..A3, then `Start` addr 0x01000 with len 4. The engine model yields 4 times, then done. Required: `BurstDataOut` shows A0..A3 in order, `BurstAddrOut`=0x01000, `Complete` pulses once, FIFO is empty, `Short`=0.
- `Start` len 3 with the FIFO empty, then push 3 words over 5 cycles. Required: `BurstCE` stays low until count reaches 3, then rises one cycle later.
- `Start` with len 0 and with len 17. Required: `CmdError` pulses each time, `Busy` stays 0.
- Len 4, the engine yields 2 times then done. Required: `Short`=1, two discard pops, `Complete` pulses, and words pushed afterwards emerge first in the next burst.
- Len 2 with 3 yields. Required: `OverYield`=1, the third cycle shows `BurstDataOut`=0x0000, FIFO count unchanged by the third yield.
- Fill the FIFO to 16 with `WrValid` held high. Required: `WrReady`=0 and the 17th word is dropped. Assert `Reset` mid-BURST. Required: next cycle `BurstCE`=0, `WrReady`=1, `Busy`=0.

Source files
------------

// File: rtl/cram_burst_feeder_pkg.sv
// Shared constants and FSM encoding for the CellularRAM burst feeder.
package cram_burst_feeder_pkg;

    localparam int unsigned CRAM_DATA_W = 16;
    localparam int unsigned CRAM_ADDR_W = 20;
    localparam int unsigned MAX_BURST   = 16;
    localparam int unsigned LEN_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_BURST     = 2'd2,
        ST_FINISH    = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/cram_burst_feeder_if.sv
// User write port, burst command/status and engine-facing signals of the feeder.
interface cram_burst_feeder_if
    import cram_burst_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = CRAM_DATA_W,
    parameter int unsigned ADDR_W = CRAM_ADDR_W
);
    logic [DATA_W-1:0] WrData;
    logic              WrValid;
    logic              WrReady;
    logic [ADDR_W-1:0] StartAddr;
    logic [LEN_W-1:0]  Length;
    logic              Start;
    logic              Busy;
    logic              Complete;
    logic              Short;
    logic              OverYield;
    logic              CmdError;
    logic [DATA_W-1:0] BurstDataOut;
    logic [ADDR_W-1:0] BurstAddrOut;
    logic              BurstCE;
    logic              BurstYield;
    logic              BurstDone;

    modport master (
        output WrData, WrValid, StartAddr, Length, Start, BurstYield, BurstDone,
        input  WrReady, Busy, Complete, Short, OverYield, CmdError,
               BurstDataOut, BurstAddrOut, BurstCE
    );

    modport slave (
        input  WrData, WrValid, StartAddr, Length, Start, BurstYield, BurstDone,
        output WrReady, Busy, Complete, Short, OverYield, CmdError,
               BurstDataOut, BurstAddrOut, BurstCE
    );
endinterface

// File: rtl/cram_burst_feeder_burst_word_fifo.sv
// Show-ahead word FIFO with occupancy count; push and pop may coincide.
module burst_word_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end
endmodule

// File: rtl/cram_burst_feeder.sv
// Burst request stage: buffers write words, gates the engine CE for one burst
// and reports short / over-run bursts.
module cram_burst_feeder
    import cram_burst_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = CRAM_DATA_W,
    parameter int unsigned ADDR_W = CRAM_ADDR_W,
    parameter int unsigned DEPTH  = MAX_BURST
) (
    input  logic                CLK,
    input  logic                Reset,
    cram_burst_feeder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [LEN_W-1:0]  discard_q, discard_d;
    logic              short_q, short_d;
    logic              over_q, over_d;
    logic              complete_q, complete_d;
    logic              cmd_err_q, cmd_err_d;
    logic              busy_q, busy_d;
    logic              ce_q, ce_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic              len_ok;

    burst_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (Reset),
        .push_i      (bus.WrValid),
        .push_data_i (bus.WrData),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign len_ok = (bus.Length != '0) && (bus.Length <= LEN_W'(DEPTH));

    // State and status registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            wcnt_q     <= '0;
            discard_q  <= '0;
            short_q    <= 1'b0;
            over_q     <= 1'b0;
            complete_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            discard_q  <= discard_d;
            short_q    <= short_d;
            over_q     <= over_d;
            complete_q <= complete_d;
            cmd_err_q  <= cmd_err_d;
            busy_q     <= busy_d;
            ce_q       <= ce_d;
        end
    end

    // Next-state, counters, sticky flags and FIFO pop.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        discard_d = discard_q;
        short_d   = short_q;
        over_d    = over_q;
        cmd_err_d = 1'b0;
        fifo_pop  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (len_ok) begin
                        addr_d    = bus.StartAddr;
                        len_d     = bus.Length;
                        wcnt_d    = '0;
                        discard_d = '0;
                        short_d   = 1'b0;
                        over_d    = 1'b0;
                        state_d   = ST_WAIT_DATA;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (fifo_count >= CNT_W'(len_q)) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (bus.BurstYield) begin
                    if (wcnt_q < len_q) begin
                        fifo_pop = 1'b1;
                        wcnt_d   = wcnt_q + LEN_W'(1);
                    end else begin
                        over_d = 1'b1;
                    end
                end
                // Short evaluation sees the count already advanced by a same-cycle yield.
                if (bus.BurstDone) begin
                    state_d = ST_FINISH;
                    if (wcnt_d < len_q) begin
                        short_d   = 1'b1;
                        discard_d = len_q - wcnt_d;
                    end else begin
                        discard_d = '0;
                    end
                end
            end
            ST_FINISH: begin
                if (discard_q != '0) begin
                    fifo_pop  = !fifo_empty;
                    discard_d = discard_q - LEN_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        complete_d = (state_d == ST_FINISH) && (discard_d == '0);
        busy_d     = (state_d != ST_IDLE);
        ce_d       = (state_d == ST_BURST);
    end

    assign bus.WrReady      = !fifo_full;
    assign bus.Busy         = busy_q;
    assign bus.BurstCE      = ce_q;
    assign bus.Complete     = complete_q;
    assign bus.CmdError     = cmd_err_q;
    assign bus.Short        = short_q;
    assign bus.OverYield    = over_q;
    assign bus.BurstAddrOut = addr_q;
    // Words past the burst length read as zero rather than the next FIFO entry.
    assign bus.BurstDataOut = (state_q == ST_BURST && wcnt_q < len_q) ? fifo_head : '0;

endmodule

// File: tb/tb_cram_burst_feeder.sv
// Self-checking bench for cram_burst_feeder: table-driven bursts plus corner sequences.
module tb_cram_burst_feeder;
    import cram_burst_feeder_pkg::*;

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_errors;
    logic [15:0] sb[$];

    cram_burst_feeder_if bus ();

    cram_burst_feeder dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int          n_push;
        logic [15:0] base;
        logic [19:0] addr;
        logic [4:0]  len;
        int          n_yield;
        logic        exp_short;
        logic        exp_over;
    } vec_t;

    vec_t vecs[5];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            bus.WrValid = 1'b1;
            bus.WrData  = base + 16'(i);
            sb.push_back(base + 16'(i));
            tick();
        end
        bus.WrValid = 1'b0;
    endtask

    // Drive the engine side from BurstCE high through Complete.
    task automatic finish_burst(input logic [19:0] addr, input logic [4:0] len, input int n_yield,
                                input logic exp_short, input logic exp_over);
        int          consumed;
        int          comp;
        logic [15:0] exp_d;
        consumed = 0;
        comp     = 0;
        check("addr_out", 32'(bus.BurstAddrOut), 32'(addr));
        for (int y = 0; y < n_yield; y++) begin
            if (consumed < int'(len)) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                consumed++;
            end else begin
                exp_d = 16'h0000;
            end
            check("burst_data", 32'(bus.BurstDataOut), 32'(exp_d));
            bus.BurstYield = 1'b1;
            bus.BurstDone  = (y == n_yield - 1);
            tick();
        end
        bus.BurstYield = 1'b0;
        bus.BurstDone  = 1'b0;
        check("ce_drop", 32'(bus.BurstCE), 32'(0));
        for (int d = consumed; d < int'(len); d++) begin
            if (sb.size() > 0) void'(sb.pop_front());
        end
        for (int k = 0; k < 24; k++) begin
            if (bus.Complete) comp++;
            if (!bus.Busy) break;
            tick();
        end
        check("complete_pulses", 32'(comp), 32'(1));
        check("idle_after", 32'(bus.Busy), 32'(0));
        check("short_flag", 32'(bus.Short), 32'(exp_short));
        check("over_flag", 32'(bus.OverYield), 32'(exp_over));
    endtask

    task automatic start_cmd(input logic [19:0] addr, input logic [4:0] len);
        bus.StartAddr = addr;
        bus.Length    = len;
        bus.Start     = 1'b1;
        tick();
        bus.Start     = 1'b0;
    endtask

    task automatic wait_ce(output bit ok);
        int waited;
        waited = 0;
        while (!bus.BurstCE && waited < 40) begin
            tick();
            waited++;
        end
        ok = bus.BurstCE;
        check("ce_rise", 32'(bus.BurstCE), 32'(1));
    endtask

    task automatic run_burst(input vec_t v);
        bit ok;
        push_words(v.n_push, v.base);
        start_cmd(v.addr, v.len);
        check("busy_after_start", 32'(bus.Busy), 32'(1));
        wait_ce(ok);
        if (ok) finish_burst(v.addr, v.len, v.n_yield, v.exp_short, v.exp_over);
    endtask

    initial begin
        bit ok;
        n_checks = 0;
        n_errors = 0;
        bus.WrData = '0;  bus.WrValid = 1'b0;
        bus.StartAddr = '0; bus.Length = '0; bus.Start = 1'b0;
        bus.BurstYield = 1'b0; bus.BurstDone = 1'b0;

        // n_push, base, addr, len, n_yield, short, over
        vecs[0] = '{4,  16'hA000, 20'h01000, 5'd4,  4,  1'b0, 1'b0};
        vecs[1] = '{4,  16'hB000, 20'h02000, 5'd4,  2,  1'b1, 1'b0};
        vecs[2] = '{3,  16'hB100, 20'h03000, 5'd2,  3,  1'b0, 1'b1};
        vecs[3] = '{0,  16'h0000, 20'h04000, 5'd1,  1,  1'b0, 1'b0};
        vecs[4] = '{16, 16'h5000, 20'hFFFFF, 5'd16, 16, 1'b0, 1'b0};

        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_wrready", 32'(bus.WrReady), 32'(1));
        check("rst_busy", 32'(bus.Busy), 32'(0));
        check("rst_ce", 32'(bus.BurstCE), 32'(0));
        check("rst_complete", 32'(bus.Complete), 32'(0));
        check("rst_flags", {29'd0, bus.Short, bus.OverYield, bus.CmdError}, 32'(0));
        check("rst_data", 32'(bus.BurstDataOut), 32'(0));
        check("rst_addr", 32'(bus.BurstAddrOut), 32'(0));

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Illegal lengths are rejected with a one-cycle error pulse.
        begin
            logic [4:0] bad_len[2];
            bad_len[0] = 5'd0;
            bad_len[1] = 5'd17;
            for (int i = 0; i < 2; i++) begin
                start_cmd(20'h00123, bad_len[i]);
                check("cmd_error", 32'(bus.CmdError), 32'(1));
                check("cmd_error_busy", 32'(bus.Busy), 32'(0));
                tick();
                check("cmd_error_pulse", 32'(bus.CmdError), 32'(0));
            end
        end

        // Start before data arrives: CE waits for the third word.
        start_cmd(20'h00777, 5'd3);
        for (int i = 0; i < 5; i++) begin
            check("ce_wait", 32'(bus.BurstCE), 32'(0));
            bus.WrValid = (i % 2 == 0);
            bus.WrData  = 16'hE000 + 16'(i);
            if (i % 2 == 0) sb.push_back(16'hE000 + 16'(i));
            tick();
        end
        bus.WrValid = 1'b0;
        check("ce_wait_count_met", 32'(bus.BurstCE), 32'(0));
        tick();
        check("ce_rise_late", 32'(bus.BurstCE), 32'(1));
        if (bus.BurstCE) finish_burst(20'h00777, 5'd3, 3, 1'b0, 1'b0);

        // Fill to full; the 17th word must be dropped.
        for (int i = 0; i < 17; i++) begin
            bus.WrValid = 1'b1;
            bus.WrData  = 16'hC000 + 16'(i);
            check("wrready_fill", 32'(bus.WrReady), 32'(i < 16));
            if (i < 16) sb.push_back(16'hC000 + 16'(i));
            tick();
        end
        bus.WrValid = 1'b0;
        check("wrready_full", 32'(bus.WrReady), 32'(0));
        start_cmd(20'h0ABCD, 5'd16);
        wait_ce(ok);
        if (ok) finish_burst(20'h0ABCD, 5'd16, 16, 1'b0, 1'b0);
        check("wrready_drained", 32'(bus.WrReady), 32'(1));

        // Reset in the middle of a burst.
        push_words(4, 16'hD000);
        start_cmd(20'h00400, 5'd4);
        wait_ce(ok);
        check("pre_reset_data", 32'(bus.BurstDataOut), 32'(16'hD000));
        bus.BurstYield = 1'b1;
        tick();
        bus.BurstYield = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb.delete();
        check("reset_ce", 32'(bus.BurstCE), 32'(0));
        check("reset_wrready", 32'(bus.WrReady), 32'(1));
        check("reset_busy", 32'(bus.Busy), 32'(0));
        check("reset_short", 32'(bus.Short), 32'(0));
        // Buffered words were lost: a one-word burst must stall.
        start_cmd(20'h00010, 5'd1);
        repeat (4) tick();
        check("reset_fifo_empty", 32'(bus.BurstCE), 32'(0));
        check("reset_wait_busy", 32'(bus.Busy), 32'(1));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
